// File: rtl/spi_slv_rx.sv
// Oversampled SPI slave receiver for the 24-bit command link: synchronizes SCLK/CSB/MOSI,
// checks the frame CRC, issues register write/read strobes and returns read data on MISO.
module spi_slv_rx #(
    parameter int MODE     = 0,
    parameter int FRM_BITS = 24,
    parameter int SYNC_STG = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_csb,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_wr_en,
    output logic [6:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_rd_en,
    output logic [6:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_crc_err,
    output logic       o_frm_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, EXEC} state_t;

    // CRC-8, polynomial x^8+x^2+x+1, zero init, 16 data bits MSB first
    function automatic logic [7:0] crc16to8(input logic [15:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    state_t              state;
    logic [SYNC_STG-1:0] sclk_sync;
    logic [SYNC_STG-1:0] csb_sync;
    logic [SYNC_STG-1:0] mosi_sync;
    logic                sclk_d;
    logic                csb_d;
    logic [SYNC_STG:0]   sync_vld;
    logic                armed;
    logic [4:0]          bit_cnt;
    logic [1:0]          fcnt;
    logic [23:0]         rx_sr;
    logic [23:0]         tx_sr;
    logic [6:0]          last_addr;
    logic [7:0]          rd_buf;
    logic                rd_pend;

    logic        sclk_s;
    logic        csb_s;
    logic        mosi_s;
    logic        rise;
    logic        fall;
    logic        csb_fall;
    logic        csb_rise;
    logic        crc_ok;
    logic [23:0] tx_load;

    assign sclk_s   = sclk_sync[SYNC_STG-1];
    assign csb_s    = csb_sync[SYNC_STG-1];
    assign mosi_s   = mosi_sync[SYNC_STG-1];
    assign rise     = sclk_s & ~sclk_d & ~csb_s;
    assign fall     = ~sclk_s & sclk_d & ~csb_s;
    // A CSB fall only counts once CSB has been seen high through a settled synchronizer,
    // so a frame already in progress when reset releases is ignored.
    assign csb_fall = armed & csb_d & ~csb_s;
    assign csb_rise = csb_s & ~csb_d;
    assign crc_ok   = (crc16to8(rx_sr[23:8]) == rx_sr[7:0]);
    assign tx_load  = {1'b0, last_addr, rd_buf, crc16to8({1'b0, last_addr, rd_buf})};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            sclk_sync <= '0;
            csb_sync  <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            csb_d     <= 1'b1;
            sync_vld  <= '0;
            armed     <= 1'b0;
            bit_cnt   <= '0;
            fcnt      <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            last_addr <= '0;
            rd_buf    <= '0;
            rd_pend   <= 1'b0;
            o_miso    <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_rd_en   <= 1'b0;
            o_rd_addr <= '0;
            o_crc_err <= 1'b0;
            o_frm_err <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STG-2:0], i_sclk};
            csb_sync  <= {csb_sync[SYNC_STG-2:0], i_csb};
            mosi_sync <= {mosi_sync[SYNC_STG-2:0], i_mosi};
            sclk_d    <= sclk_s;
            csb_d     <= csb_s;
            sync_vld  <= {sync_vld[SYNC_STG-1:0], 1'b1};
            if (sync_vld[SYNC_STG] && csb_s)
                armed <= 1'b1;

            o_wr_en   <= 1'b0;
            o_rd_en   <= 1'b0;
            o_crc_err <= 1'b0;
            o_frm_err <= 1'b0;

            // Read data arrives one cycle after the strobe
            rd_pend <= o_rd_en;
            if (rd_pend)
                rd_buf <= i_rd_data;

            case (state)
                IDLE: begin
                    if (csb_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        fcnt    <= '0;
                        tx_sr   <= tx_load;
                        o_miso  <= (MODE == 0) ? tx_load[23] : 1'b0;
                    end
                end
                SHIFT: begin
                    if (csb_rise) begin
                        state <= CHECK;
                    end else begin
                        if (rise) begin
                            rx_sr <= {rx_sr[22:0], mosi_s};
                            if (bit_cnt == 5'(FRM_BITS - 1)) begin
                                bit_cnt <= '0;
                                if (fcnt != 2'd3)
                                    fcnt <= fcnt + 2'd1;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                        if (fall) begin
                            if (MODE == 0) begin
                                o_miso <= tx_sr[22];
                                tx_sr  <= {tx_sr[22:0], 1'b0};
                            end else begin
                                o_miso <= rx_sr[23];
                            end
                        end
                    end
                end
                CHECK: begin
                    if (bit_cnt != '0 || fcnt == '0) begin
                        o_frm_err <= 1'b1;
                        state     <= IDLE;
                    end else if (!crc_ok) begin
                        o_crc_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (rx_sr[23]) begin
                        o_wr_en   <= 1'b1;
                        o_wr_addr <= rx_sr[22:16];
                        o_wr_data <= rx_sr[15:8];
                    end else begin
                        o_rd_en   <= 1'b1;
                        o_rd_addr <= rx_sr[22:16];
                        last_addr <= rx_sr[22:16];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slv_rx.sv
// Scoreboard bench for spi_slv_rx: a MODE=0 and a MODE=1 instance share the SPI bus; a
// frame-level reference model predicts strobes/errors and MISO bits.
module tb_spi_slv_rx;

    localparam int HALF = 8;

    typedef struct packed {
        logic [3:0] kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    localparam logic [3:0] K_WR = 4'b1000, K_RD = 4'b0100, K_CRC = 4'b0010, K_FRM = 4'b0001;

    logic i_clk = 1'b0, i_rst_n = 1'b0, i_sclk = 1'b0, i_csb = 1'b1, i_mosi = 1'b0;
    logic       miso0, wr_en0, rd_en0, crc_err0, frm_err0;
    logic [6:0] wr_addr0, rd_addr0;
    logic [7:0] wr_data0, rd_data0 = 8'h00;
    logic       miso1, wr_en1, rd_en1, crc_err1, frm_err1;
    logic [6:0] wr_addr1, rd_addr1;
    logic [7:0] wr_data1, rd_data1 = 8'h00;

    int   n_vec  = 0;
    int   n_miss = 0;
    ev_t  q0[$], q1[$];
    ev_t  act0, act1, exp0, exp1;
    logic [7:0] mem [128];
    logic [6:0] m_last_addr = '0;
    logic [7:0] m_rd_buf    = '0;

    always #5 i_clk = ~i_clk;

    spi_slv_rx #(.MODE(0)) u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_csb(i_csb), .i_mosi(i_mosi),
        .o_miso(miso0), .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
        .o_rd_en(rd_en0), .o_rd_addr(rd_addr0), .i_rd_data(rd_data0),
        .o_crc_err(crc_err0), .o_frm_err(frm_err0)
    );

    spi_slv_rx #(.MODE(1)) u_dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sclk(i_sclk), .i_csb(i_csb), .i_mosi(i_mosi),
        .o_miso(miso1), .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
        .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
        .o_crc_err(crc_err1), .o_frm_err(frm_err1)
    );

    // CRC by polynomial long division of {data, 8'h00} by 0x107
    function automatic logic [7:0] ref_crc(input logic [15:0] d);
        logic [23:0] r;
        r = {d, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (r[i]) r = r ^ (24'h107 << (i - 8));
        return r[7:0];
    endfunction

    function automatic logic [23:0] mk_frame(input logic rw, input logic [6:0] addr,
                                             input logic [7:0] data, input logic flip);
        logic [15:0] hdr;
        hdr = {rw, addr, data};
        return {hdr, ref_crc(hdr) ^ {7'd0, flip}};
    endfunction

    function automatic ev_t mk_ev(input logic [3:0] kind, input logic [6:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Register file responder: registered read, garbage whenever no read is pending
    always @(posedge i_clk) begin
        rd_data0 <= rd_en0 ? mem[rd_addr0] : 8'($urandom);
        rd_data1 <= rd_en1 ? mem[rd_addr1] : 8'($urandom);
    end

    // Monitor: every strobe/error pulse must match the next expected event
    always @(negedge i_clk) begin
        if (i_rst_n && (wr_en0 || rd_en0 || crc_err0 || frm_err0)) begin
            act0.kind = {wr_en0, rd_en0, crc_err0, frm_err0};
            act0.addr = wr_en0 ? wr_addr0 : (rd_en0 ? rd_addr0 : 7'd0);
            act0.data = wr_en0 ? wr_data0 : 8'd0;
            if (q0.size() == 0) begin
                checkOutput("dut0 unexpected strobe", 64'(act0), 64'd0);
            end else begin
                exp0 = q0.pop_front();
                checkOutput("dut0 strobe", 64'(act0), 64'(exp0));
            end
        end
        if (i_rst_n && (wr_en1 || rd_en1 || crc_err1 || frm_err1)) begin
            act1.kind = {wr_en1, rd_en1, crc_err1, frm_err1};
            act1.addr = wr_en1 ? wr_addr1 : (rd_en1 ? rd_addr1 : 7'd0);
            act1.data = wr_en1 ? wr_data1 : 8'd0;
            if (q1.size() == 0) begin
                checkOutput("dut1 unexpected strobe", 64'(act1), 64'd0);
            end else begin
                exp1 = q1.pop_front();
                checkOutput("dut1 strobe", 64'(act1), 64'(exp1));
            end
        end
    end

    task automatic checkResetOutputs();
        checkOutput("dut0 outputs in reset",
            64'({miso0, wr_en0, wr_addr0, wr_data0, rd_en0, rd_addr0, crc_err0, frm_err0}), 64'd0);
        checkOutput("dut1 outputs in reset",
            64'({miso1, wr_en1, wr_addr1, wr_data1, rd_en1, rd_addr1, crc_err1, frm_err1}), 64'd0);
    endtask

    // One CSB session; bit k of the session is bits[47-k]. rst_at >= 0 pulses reset before that bit.
    task automatic applyStimulus(input logic [47:0] bits, input int nbits, input int rst_at);
        logic [23:0] resp;
        logic [23:0] last;
        logic        e0, e1;
        bit          was_reset;
        ev_t         ev;
        was_reset = 0;
        resp = {1'b0, m_last_addr, m_rd_buf, ref_crc({1'b0, m_last_addr, m_rd_buf})};
        i_csb = 1'b0;
        waitCycles(HALF);
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) begin
                i_rst_n = 1'b0;
                waitCycles(3);
                checkResetOutputs();
                i_rst_n     = 1'b1;
                m_last_addr = '0;
                m_rd_buf    = '0;
                was_reset   = 1;
            end
            i_mosi = bits[47-k];
            waitCycles(HALF);
            if (!was_reset) begin
                e0 = (k < 24) ? resp[23-k] : 1'b0;
                checkOutput("dut0 miso bit", 64'(miso0), 64'(e0));
                if (k >= 24) begin
                    e1 = bits[71-k];
                    checkOutput("dut1 miso bit", 64'(miso1), 64'(e1));
                end
            end
            i_sclk = 1'b1;
            waitCycles(HALF);
            i_sclk = 1'b0;
        end
        waitCycles(HALF);
        if (!was_reset) begin
            if (nbits == 0 || (nbits % 24) != 0) begin
                ev = mk_ev(K_FRM, 7'd0, 8'd0);
            end else begin
                last = bits[71-nbits -: 24];
                if (ref_crc(last[23:8]) != last[7:0]) begin
                    ev = mk_ev(K_CRC, 7'd0, 8'd0);
                end else if (last[23]) begin
                    ev = mk_ev(K_WR, last[22:16], last[15:8]);
                end else begin
                    ev = mk_ev(K_RD, last[22:16], 8'd0);
                    m_last_addr = last[22:16];
                    m_rd_buf    = mem[last[22:16]];
                end
            end
            q0.push_back(ev);
            q1.push_back(ev);
        end
        i_csb = 1'b1;
        for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0); i++)
            waitCycles(1);
        checkOutput("strobe drain", 64'(q0.size() + q1.size()), 64'd0);
        q0.delete();
        q1.delete();
        waitCycles(20);
    endtask

    initial begin
        logic [23:0] fa, fb;
        int          len, sel;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[7'h40] = 8'hA5;

        waitCycles(5);
        checkResetOutputs();
        i_rst_n = 1'b1;
        waitCycles(10);

        $display("[TB] directed frames");
        applyStimulus({mk_frame(1'b1, 7'h40, 8'h80, 1'b0), 24'd0}, 24, -1);
        applyStimulus({mk_frame(1'b0, 7'h40, 8'h80, 1'b0), 24'd0}, 24, -1);
        applyStimulus({mk_frame(1'b1, 7'h40, 8'h80, 1'b0), 24'd0}, 24, -1);
        applyStimulus({mk_frame(1'b1, 7'h40, 8'h80, 1'b1), 24'd0}, 24, -1);
        applyStimulus({mk_frame(1'b1, 7'h12, 8'h34, 1'b0), 24'd0}, 13, -1);
        applyStimulus({mk_frame(1'b1, 7'h12, 8'h34, 1'b0), 24'd0}, 24, -1);
        applyStimulus(48'd0, 0, -1);

        $display("[TB] daisy-chain two-frame session");
        fa = mk_frame(1'b0, 7'h2B, 8'hC3, 1'b0);
        fb = mk_frame(1'b1, 7'h55, 8'h0F, 1'b0);
        applyStimulus({fa, fb}, 48, -1);

        $display("[TB] reset mid-frame");
        applyStimulus({mk_frame(1'b1, 7'h33, 8'h99, 1'b0), 24'd0}, 24, 10);
        applyStimulus({mk_frame(1'b1, 7'h33, 8'h99, 1'b0), 24'd0}, 24, -1);

        $display("[TB] random frames");
        for (int n = 0; n < 30; n++) begin
            fa  = mk_frame(1'($urandom), 7'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
            fb  = mk_frame(1'($urandom), 7'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0));
            sel = $urandom_range(0, 7);
            if (sel == 0) begin
                len = 48;
            end else if (sel == 1) begin
                len = $urandom_range(1, 47);
                if (len == 24) len = 23;
            end else begin
                len = 24;
            end
            applyStimulus({fa, fb}, len, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

endmodule
